mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It sits between the execute stage and the M/W pipeline register and produces the record the writeback stage consumes: result, destination register, write enable and PC. It issues data-memory requests over an SRAM-like handshake, aligns and extends loads, and builds byte strobes for stores. It detects address-alignment exceptions and stalls upstream while a bus transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 23 ++
 rtl/mem_align.sv | 44 ++++
 rtl/mem_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types for the MIPS memory-access stage: access sizes, exception codes
// and bus FSM states.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    SzByte = 2'd0,
    SzHalf = 2'd1,
    SzWord = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    ExcNone = 2'd0,
    ExcAdel = 2'd1,
    ExcAdes = 2'd2
  } exc_t;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane logic for data-memory accesses: store strobes and replication,
// load extraction with sign/zero extension, and alignment checking.
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr,
  input  msize_t      size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v     = rdata[{addr, 3'b000} +: 8];
    half_v     = rdata[{addr[1], 4'b0000} +: 16];
    strb       = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = rdata;
    misaligned = 1'b0;
    case (size)
      SzByte: begin
        strb      = 4'b0001 << addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{sign_ext & byte_v[7]}}, byte_v};
      end
      SzHalf: begin
        strb       = 4'b0011 << {addr[1], 1'b0};
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{sign_ext & half_v[15]}}, half_v};
        misaligned = addr[0];
      end
      // Word and the unused encoding both need a word-aligned address.
      default: misaligned = (addr != 2'b00);
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory-access stage: issues SRAM-like data requests, aligns loads,
// raises address exceptions and holds the record for writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [1:0]        in_size,
  input  logic              in_signed,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [ADDR_W-1:0] in_wdata,
  input  logic [ADDR_W-1:0] in_aluout,
  input  logic [4:0]        in_writereg,
  input  logic              in_regwrite,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              dreq_valid,
  output logic              dreq_wr,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [3:0]        dreq_strb,
  output logic [ADDR_W-1:0] dreq_wdata,
  input  logic              dreq_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [ADDR_W-1:0] dresp_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_result,
  output logic [4:0]        out_writereg,
  output logic              out_regwrite,
  output logic [ADDR_W-1:0] out_pc,
  output logic [1:0]        out_exc,
  output logic [ADDR_W-1:0] out_badvaddr
);

  mem_state_t state_q, state_d;
  logic killed_q, killed_d;

  // Captured at accept; drives the bus request and the response alignment.
  logic              req_wr_q, req_signed_q, pend_read_q, pend_regwrite_q;
  logic [ADDR_W-1:0] req_addr_q, req_wdata_q, pend_result_q, pend_pc_q;
  logic [3:0]        req_strb_q;
  msize_t            req_size_q;
  logic [4:0]        pend_writereg_q;

  logic              out_valid_q, out_valid_d, out_regwrite_q, out_regwrite_d;
  logic [ADDR_W-1:0] out_result_q, out_result_d, out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] out_badvaddr_q, out_badvaddr_d;
  logic [4:0]        out_writereg_q, out_writereg_d;
  exc_t              out_exc_q, out_exc_d;

  logic        idle, mem_op, accept, accept_mem, done;
  logic [1:0]  al_addr;
  msize_t      al_size;
  logic        al_signed, misaligned;
  logic [3:0]  al_strb;
  logic [31:0] al_wdata, al_rdata;

  assign idle   = (state_q == StIdle);
  assign mem_op = in_memread | in_memwrite;

  // One aligner serves the incoming instruction in IDLE and the pending response otherwise.
  assign al_addr   = idle ? in_addr[1:0] : req_addr_q[1:0];
  assign al_size   = idle ? msize_t'(in_size) : req_size_q;
  assign al_signed = idle ? in_signed : req_signed_q;

  mem_align u_align (
    .addr       (al_addr),
    .size       (al_size),
    .sign_ext   (al_signed),
    .wdata      (in_wdata),
    .rdata      (dresp_rdata),
    .strb       (al_strb),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata),
    .misaligned (misaligned)
  );

  assign in_ready   = idle & (~out_valid_q | out_ready);
  assign accept     = in_valid & in_ready & ~flush;
  assign accept_mem = accept & mem_op & ~misaligned;
  assign done       = ~idle & dresp_data_ok;

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    unique case (state_q)
      StIdle: if (accept_mem) state_d = StReq;
      StReq: begin
        if (dresp_data_ok)     state_d = StIdle;
        else if (dreq_addr_ok) state_d = StWait;
      end
      StWait: if (dresp_data_ok) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (done)                killed_d = 1'b0;
    else if (flush && !idle) killed_d = 1'b1;
  end

  always_comb begin
    out_valid_d    = out_valid_q & ~out_ready;
    out_result_d   = out_result_q;
    out_writereg_d = out_writereg_q;
    out_regwrite_d = out_regwrite_q;
    out_pc_d       = out_pc_q;
    out_exc_d      = out_exc_q;
    out_badvaddr_d = out_badvaddr_q;
    if (accept && !accept_mem) begin
      out_valid_d    = 1'b1;
      out_result_d   = in_aluout;
      out_writereg_d = in_writereg;
      out_pc_d       = in_pc;
      if (mem_op && misaligned) begin
        out_exc_d      = in_memread ? ExcAdel : ExcAdes;
        out_regwrite_d = 1'b0;
        out_badvaddr_d = in_addr;
      end else begin
        out_exc_d      = ExcNone;
        out_regwrite_d = in_regwrite;
        out_badvaddr_d = '0;
      end
    end
    if (done && !killed_q && !flush) begin
      out_valid_d    = 1'b1;
      out_result_d   = pend_read_q ? al_rdata : pend_result_q;
      out_writereg_d = pend_writereg_q;
      out_regwrite_d = pend_regwrite_q;
      out_pc_d       = pend_pc_q;
      out_exc_d      = ExcNone;
      out_badvaddr_d = '0;
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      killed_q       <= 1'b0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_writereg_q <= '0;
      out_regwrite_q <= 1'b0;
      out_pc_q       <= '0;
      out_exc_q      <= ExcNone;
      out_badvaddr_q <= '0;
    end else begin
      state_q        <= state_d;
      killed_q       <= killed_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_writereg_q <= out_writereg_d;
      out_regwrite_q <= out_regwrite_d;
      out_pc_q       <= out_pc_d;
      out_exc_q      <= out_exc_d;
      out_badvaddr_q <= out_badvaddr_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      req_wr_q        <= 1'b0;
      req_addr_q      <= '0;
      req_strb_q      <= '0;
      req_wdata_q     <= '0;
      req_size_q      <= SzByte;
      req_signed_q    <= 1'b0;
      pend_read_q     <= 1'b0;
      pend_result_q   <= '0;
      pend_writereg_q <= '0;
      pend_regwrite_q <= 1'b0;
      pend_pc_q       <= '0;
    end else if (accept_mem) begin
      req_wr_q        <= ~in_memread;
      req_addr_q      <= in_addr;
      req_strb_q      <= al_strb;
      req_wdata_q     <= al_wdata;
      req_size_q      <= msize_t'(in_size);
      req_signed_q    <= in_signed;
      pend_read_q     <= in_memread;
      pend_result_q   <= in_aluout;
      pend_writereg_q <= in_writereg;
      pend_regwrite_q <= in_regwrite;
      pend_pc_q       <= in_pc;
    end
  end

  assign dreq_valid   = (state_q == StReq);
  assign dreq_wr      = req_wr_q;
  assign dreq_addr    = {req_addr_q[ADDR_W-1:2], 2'b00};
  assign dreq_strb    = req_strb_q;
  assign dreq_wdata   = req_wdata_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_writereg = out_writereg_q;
  assign out_regwrite = out_regwrite_q;
  assign out_pc       = out_pc_q;
  assign out_exc      = out_exc_q;
  assign out_badvaddr = out_badvaddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage with hand-computed expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn, flush, in_valid, in_ready, in_memread, in_memwrite, in_signed;
  logic [1:0]  in_size;
  logic [31:0] in_addr, in_wdata, in_aluout, in_pc;
  logic [4:0]  in_writereg;
  logic        in_regwrite;
  logic        dreq_valid, dreq_wr, dreq_addr_ok, dresp_data_ok;
  logic [31:0] dreq_addr, dreq_wdata, dresp_rdata;
  logic [3:0]  dreq_strb;
  logic        out_valid, out_ready, out_regwrite;
  logic [31:0] out_result, out_pc, out_badvaddr;
  logic [4:0]  out_writereg;
  logic [1:0]  out_exc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .resetn        (resetn),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_memread    (in_memread),
    .in_memwrite   (in_memwrite),
    .in_size       (in_size),
    .in_signed     (in_signed),
    .in_addr       (in_addr),
    .in_wdata      (in_wdata),
    .in_aluout     (in_aluout),
    .in_writereg   (in_writereg),
    .in_regwrite   (in_regwrite),
    .in_pc         (in_pc),
    .dreq_valid    (dreq_valid),
    .dreq_wr       (dreq_wr),
    .dreq_addr     (dreq_addr),
    .dreq_strb     (dreq_strb),
    .dreq_wdata    (dreq_wdata),
    .dreq_addr_ok  (dreq_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_rdata   (dresp_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_writereg  (out_writereg),
    .out_regwrite  (out_regwrite),
    .out_pc        (out_pc),
    .out_exc       (out_exc),
    .out_badvaddr  (out_badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] alu,
                        input logic [4:0] wreg, input logic rw, input logic [31:0] pc);
    in_valid    = 1'b1;
    in_memread  = rd;
    in_memwrite = wr;
    in_size     = sz;
    in_signed   = sg;
    in_addr     = addr;
    in_wdata    = wd;
    in_aluout   = alu;
    in_writereg = wreg;
    in_regwrite = rw;
    in_pc       = pc;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    resetn = 1'b0; flush = 1'b0; out_ready = 1'b1;
    dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_rdata = '0;
    set_op(1'b0, 1'b0, 2'd0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_dreq_valid", {31'd0, dreq_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    resetn = 1'b1;
    tick();

    // ALU op
    set_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h400);
    tick();
    in_valid = 1'b0;
    chk("alu_valid", {31'd0, out_valid}, 32'd1);
    chk("alu_result", out_result, 32'h1234);
    chk("alu_wreg", {27'd0, out_writereg}, 32'd5);
    chk("alu_pc", out_pc, 32'h400);
    chk("alu_noreq", {31'd0, dreq_valid}, 32'd0);

    // lb signed at 0x1003
    set_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 32'h1003, 5'd8, 1'b1, 32'h404);
    tick();
    in_valid = 1'b0;
    chk("lb_req", {31'd0, dreq_valid}, 32'd1);
    chk("lb_addr", dreq_addr, 32'h1000);
    chk("lb_wr", {31'd0, dreq_wr}, 32'd0);
    chk("lb_busy", {31'd0, in_ready}, 32'd0);
    dreq_addr_ok = 1'b1;
    tick();
    dreq_addr_ok = 1'b0;
    chk("lb_wait_noreq", {31'd0, dreq_valid}, 32'd0);
    tick();
    chk("lb_wait_novalid", {31'd0, out_valid}, 32'd0);
    dresp_data_ok = 1'b1; dresp_rdata = 32'h80FF_0000;
    tick();
    dresp_data_ok = 1'b0;
    chk("lb_valid", {31'd0, out_valid}, 32'd1);
    chk("lb_result", out_result, 32'hFFFF_FF80);
    chk("lb_wreg", {27'd0, out_writereg}, 32'd8);
    chk("lb_ready", {31'd0, in_ready}, 32'd1);

    // lhu at 0x1002, best-case latency
    set_op(1'b1, 1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h0, 5'd9, 1'b1, 32'h408);
    tick();
    in_valid = 1'b0;
    dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_rdata = 32'h80FF_0000;
    tick();
    dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("lhu_result", out_result, 32'h0000_80FF);

    // sh at 0x2002
    set_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_ABCD, 32'h2002, 5'd0, 1'b0, 32'h40C);
    tick();
    in_valid = 1'b0;
    chk("sh_strb", {28'd0, dreq_strb}, 32'hC);
    chk("sh_wdata", dreq_wdata, 32'hABCD_ABCD);
    chk("sh_wr", {31'd0, dreq_wr}, 32'd1);
    chk("sh_addr", dreq_addr, 32'h2000);
    dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    chk("sh_done", {31'd0, out_valid}, 32'd1);
    chk("sh_noreq", {31'd0, dreq_valid}, 32'd0);

    // sb at 0x2001 strobe and replication
    set_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h2001, 32'h0000_0077, 32'h0, 5'd0, 1'b0, 32'h410);
    tick();
    in_valid = 1'b0;
    chk("sb_strb", {28'd0, dreq_strb}, 32'h2);
    chk("sb_wdata", dreq_wdata, 32'h7777_7777);
    dreq_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dreq_addr_ok = 1'b0; dresp_data_ok = 1'b0;

    // lw misaligned
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h0, 5'd3, 1'b1, 32'h414);
    tick();
    in_valid = 1'b0;
    chk("adel_noreq", {31'd0, dreq_valid}, 32'd0);
    chk("adel_valid", {31'd0, out_valid}, 32'd1);
    chk("adel_exc", {30'd0, out_exc}, 32'd1);
    chk("adel_bad", out_badvaddr, 32'h3001);
    chk("adel_rw", {31'd0, out_regwrite}, 32'd0);

    // sh misaligned
    set_op(1'b0, 1'b1, 2'd1, 1'b0, 32'h3003, 32'h0, 32'h0, 5'd0, 1'b0, 32'h418);
    tick();
    in_valid = 1'b0;
    chk("ades_exc", {30'd0, out_exc}, 32'd2);
    chk("ades_noreq", {31'd0, dreq_valid}, 32'd0);

    // flush while in WAIT
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h4000, 32'h0, 32'h0, 5'd4, 1'b1, 32'h41C);
    tick();
    in_valid = 1'b0;
    dreq_addr_ok = 1'b1;
    tick();
    dreq_addr_ok = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_novalid", {31'd0, out_valid}, 32'd0);
    chk("fl_busy", {31'd0, in_ready}, 32'd0);
    dresp_data_ok = 1'b1; dresp_rdata = 32'hDEAD_BEEF;
    tick();
    dresp_data_ok = 1'b0;
    chk("fl_discard", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);

    // backpressure
    out_ready = 1'b0;
    set_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'hCAFE, 5'd6, 1'b1, 32'h420);
    tick();
    in_aluout = 32'hBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", out_result, 32'hCAFE);
      chk("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next", out_result, 32'hBEEF);
    tick();

    // flush during accept drops the instruction
    set_op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h5555, 5'd7, 1'b1, 32'h424);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fa_drop", {31'd0, out_valid}, 32'd0);

    // reset mid-transaction
    set_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h5000, 32'h0, 32'h0, 5'd2, 1'b1, 32'h428);
    tick();
    in_valid = 1'b0;
    chk("rm_req", {31'd0, dreq_valid}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("rm_noreq", {31'd0, dreq_valid}, 32'd0);
    chk("rm_ready", {31'd0, in_ready}, 32'd1);
    tick();
    resetn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
